piccolo_dec: RTL

- Iterative Piccolo block-cipher decryption core, one round per clock.
- Supports Piccolo-80 (25 rounds) and Piccolo-128 (31 rounds).
- Inverse of the team's unrolled Piccolo encryption core; sits on the receive side of the same datapath.
- Ciphertext enters and plaintext leaves via valid/ready handshakes; round keys are generated on the fly in reverse order from the master key.

---
 rtl/piccolo_dec.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/piccolo_dec.sv
// piccolo_dec: iterative Piccolo-80 / Piccolo-128 decryption core, one round
// per clock. Decryption reuses the encryption round structure with reordered
// whitening keys and round keys taken from the end of the schedule. Round keys
// are derived combinationally from the latched master key and round counter.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its data until that edge, and ready
// never depends combinationally on the other side's valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   version    0 = Piccolo-80 (25 rounds), 1 = Piccolo-128 (31 rounds)
//   key_in     master key, MSB-first; Piccolo-80 uses the top 80 bits
//   in_valid   ciphertext valid
//   in_ready   core can accept a block (IDLE)
//   ciphertext input block, MSB-first
//   out_valid  plaintext valid (DONE)
//   out_ready  sink accepts plaintext
//   plaintext  decrypted block, held until taken
//   busy       high in ROUND or DONE
module piccolo_dec #(
  parameter int DATA_W = 64,
  parameter int KEY_W  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              version,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ciphertext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] plaintext,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state;
  logic         ver_q;
  logic [127:0] key_q;
  logic [63:0]  x_q;
  logic [4:0]   cnt;

  function automatic logic [3:0] sbox(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h0: r = 4'he; 4'h1: r = 4'h4; 4'h2: r = 4'hb; 4'h3: r = 4'h2;
      4'h4: r = 4'h3; 4'h5: r = 4'h8; 4'h6: r = 4'h0; 4'h7: r = 4'h9;
      4'h8: r = 4'h1; 4'h9: r = 4'ha; 4'ha: r = 4'h7; 4'hb: r = 4'hf;
      4'hc: r = 4'h6; 4'hd: r = 4'hc; 4'he: r = 4'h5; default: r = 4'hd;
    endcase
    return r;
  endfunction

  // Multiply by x in GF(2^4) mod x^4+x+1.
  function automatic logic [3:0] mul2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  function automatic logic [15:0] f_fn(input logic [15:0] x);
    logic [3:0] s0, s1, s2, s3, y0, y1, y2, y3;
    s0 = sbox(x[15:12]); s1 = sbox(x[11:8]);
    s2 = sbox(x[7:4]);   s3 = sbox(x[3:0]);
    y0 = mul2(s0) ^ mul2(s1) ^ s1 ^ s2 ^ s3;
    y1 = s0 ^ mul2(s1) ^ mul2(s2) ^ s2 ^ s3;
    y2 = s0 ^ s1 ^ mul2(s2) ^ mul2(s3) ^ s3;
    y3 = mul2(s0) ^ s0 ^ s1 ^ s2 ^ mul2(s3);
    return {sbox(y0), sbox(y1), sbox(y2), sbox(y3)};
  endfunction

  // Byte permutation (b0..b7) -> (b2,b7,b4,b1,b6,b3,b0,b5).
  function automatic logic [63:0] rp(input logic [63:0] x);
    return {x[47:40], x[7:0], x[31:24], x[55:48],
            x[15:8], x[39:32], x[63:56], x[23:16]};
  endfunction

  // 16-bit key word w, word 0 being the most significant.
  function automatic logic [15:0] kw(input logic [127:0] k, input logic [2:0] w);
    logic [127:0] s;
    s = k << ({4'b0000, w} * 7'd16);
    return s[127:112];
  endfunction

  // Source position of each word after the Piccolo-128 word shuffle.
  function automatic logic [2:0] shuffle_src(input logic [2:0] i);
    logic [2:0] r;
    case (i)
      3'd0: r = 3'd2; 3'd1: r = 3'd1; 3'd2: r = 3'd6; 3'd3: r = 3'd7;
      3'd4: r = 3'd0; 3'd5: r = 3'd3; 3'd6: r = 3'd4; default: r = 3'd5;
    endcase
    return r;
  endfunction

  // Standard round key rk_j for the selected version.
  function automatic logic [15:0] rk_fn(input logic [127:0] k, input logic ver,
                                        input logic [5:0] j);
    logic [4:0]  m, c;
    logic [31:0] con;
    logic [15:0] con_h, kk;
    logic [5:0]  s6;
    logic [2:0]  idx, n;
    m     = j[5:1];
    c     = m + 5'd1;
    con   = {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ (ver ? 32'h6547a98b : 32'h0f1e2d3c);
    con_h = j[0] ? con[15:0] : con[31:16];
    if (!ver) begin
      case (m % 5'd5)
        5'd0, 5'd2: kk = j[0] ? kw(k, 3'd3) : kw(k, 3'd2);
        5'd1, 5'd4: kk = j[0] ? kw(k, 3'd1) : kw(k, 3'd0);
        default:    kk = kw(k, 3'd4);
      endcase
    end else begin
      // Word index (j+2) mod 8 traced back through the shuffles applied so far
      // (one every 8 key words), so no schedule state is needed.
      s6  = j + 6'd2;
      idx = s6[2:0];
      n   = s6[5:3];
      for (int p = 0; p < 7; p++) begin
        if (3'(p) < n) idx = shuffle_src(idx);
      end
      kk = kw(k, idx);
    end
    return con_h ^ kk;
  endfunction

  // Standard whitening key wk_w.
  function automatic logic [15:0] wk_fn(input logic [127:0] k, input logic ver,
                                        input logic [1:0] w);
    logic [15:0] k0, k1, k4, hi, r;
    k0 = kw(k, 3'd0);
    k1 = kw(k, 3'd1);
    k4 = kw(k, 3'd4);
    hi = ver ? kw(k, 3'd7) : kw(k, 3'd3);
    case (w)
      2'd0:    r = {k0[15:8], k1[7:0]};
      2'd1:    r = {k1[15:8], k0[7:0]};
      2'd2:    r = {k4[15:8], hi[7:0]};
      default: r = {hi[15:8], k4[7:0]};
    endcase
    return r;
  endfunction

  logic [4:0]  r_last, rem;
  logic [5:0]  j_lo, j_hi;
  logic [15:0] rk_lo, rk_hi, rk_a, rk_b;
  logic [63:0] x_mix, x_init, pt_final;
  logic        last;

  always_comb begin
    r_last = ver_q ? 5'd30 : 5'd24;
    rem    = r_last - cnt;
    // Decryption round i uses rk_{2R-2i-2}, rk_{2R-2i-1}, swapped on odd i.
    j_lo   = {rem, 1'b0};
    j_hi   = {rem, 1'b1};
    rk_lo  = rk_fn(key_q, ver_q, j_lo);
    rk_hi  = rk_fn(key_q, ver_q, j_hi);
    rk_a   = cnt[0] ? rk_hi : rk_lo;
    rk_b   = cnt[0] ? rk_lo : rk_hi;
    last   = (cnt == r_last);
    x_mix  = {x_q[63:48], x_q[47:32] ^ f_fn(x_q[63:48]) ^ rk_a,
              x_q[31:16], x_q[15:0]  ^ f_fn(x_q[31:16]) ^ rk_b};
    pt_final = x_mix ^ {wk_fn(key_q, ver_q, 2'd0), 16'h0000,
                        wk_fn(key_q, ver_q, 2'd1), 16'h0000};
    x_init = ciphertext ^ {wk_fn(key_in, version, 2'd2), 16'h0000,
                           wk_fn(key_in, version, 2'd3), 16'h0000};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ver_q     <= 1'b0;
      key_q     <= '0;
      x_q       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      plaintext <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ver_q    <= version;
            key_q    <= key_in;
            x_q      <= x_init;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ROUND;
          end
        end
        ROUND: begin
          cnt <= cnt + 5'd1;
          if (last) begin
            plaintext <= pt_final;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            x_q <= rp(x_mix);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
